// File: rtl/positron_stream_feeder_if.sv
// Stream bundle between an activation/weight producer pair, the positron feeder and the downstream positron.
// master = feeder side, slave = surrounding environment.
interface positron_stream_feeder_if #(
  parameter int unsigned POSIT_WIDTH = 16
);
  logic                     act_rts_i;
  logic                     act_rtr_o;
  logic                     act_eow_i;
  logic [POSIT_WIDTH-1:0]   act_data_i;
  logic                     w_rts_i;
  logic                     w_rtr_o;
  logic [POSIT_WIDTH-1:0]   w_data_i;
  logic                     rtr_i;
  logic                     rts_o;
  logic                     sow_o;
  logic                     eow_o;
  logic [2*POSIT_WIDTH-1:0] data_o;

  modport master (
    input  act_rts_i, act_eow_i, act_data_i, w_rts_i, w_data_i, rtr_i,
    output act_rtr_o, w_rtr_o, rts_o, sow_o, eow_o, data_o
  );

  modport slave (
    output act_rts_i, act_eow_i, act_data_i, w_rts_i, w_data_i, rtr_i,
    input  act_rtr_o, w_rtr_o, rts_o, sow_o, eow_o, data_o
  );
endinterface

// File: rtl/positron_stream_feeder.sv
// Buffers one activation vector and streams {weight, activation} words framed by sow/eow for NB_NEURONS dot products.
// Optional NaR detection output enabled by defining POSITRON_FEEDER_NAR_CHECK_EN.
module positron_stream_feeder #(
  parameter int unsigned POSIT_WIDTH = 16,
  parameter int unsigned VEC_LEN     = 16,
  parameter int unsigned NB_NEURONS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  positron_stream_feeder_if.master bus,
`ifdef POSITRON_FEEDER_NAR_CHECK_EN
  output logic                     nar_o,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int unsigned IDX_W = $clog2(VEC_LEN);
  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned NRN_W = $clog2(NB_NEURONS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [NRN_W-1:0]         nrn_q;
  logic [LEN_W-1:0]         len_q;
  logic [POSIT_WIDTH-1:0]   mem [VEC_LEN];
  logic                     rts_q, sow_q, eow_q;
  logic [2*POSIT_WIDTH-1:0] data_q;
  logic                     act_rtr_q, busy_q, done_q, err_q;

  logic                     act_fire_c, w_rtr_c, w_fire_c, out_fire_c;
  logic                     idx_last_c, nrn_last_c, load_end_c;
  logic [POSIT_WIDTH-1:0]   rd_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (act_fire_c) state_d = load_end_c ? STREAM : LOAD;
      LOAD:    if (load_end_c) state_d = STREAM;
      STREAM:  if (w_fire_c && idx_last_c && nrn_last_c) state_d = DRAIN;
      DRAIN:   if (out_fire_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes; weights only flow while the output slot is free or draining this cycle.
  always_comb begin
    act_fire_c = 1'b0;
    w_rtr_c    = 1'b0;
    w_fire_c   = 1'b0;
    out_fire_c = rts_q & bus.rtr_i;
    idx_last_c = (idx_q == IDX_W'(VEC_LEN - 1));
    nrn_last_c = (nrn_q == NRN_W'(NB_NEURONS - 1));
    case (state_q)
      IDLE, LOAD: act_fire_c = act_rtr_q & bus.act_rts_i;
      STREAM: begin
        w_rtr_c  = ~rts_q | bus.rtr_i;
        w_fire_c = w_rtr_c & bus.w_rts_i;
      end
      default: ;
    endcase
    load_end_c = act_fire_c & (bus.act_eow_i | idx_last_c);
  end

  // Entries beyond a short vector read as the zero posit.
  assign rd_c = (LEN_W'(idx_q) < len_q) ? mem[idx_q] : '0;

  always_ff @(posedge clk) begin
    if (act_fire_c) mem[idx_q] <= bus.act_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      nrn_q     <= '0;
      len_q     <= '0;
      rts_q     <= 1'b0;
      sow_q     <= 1'b0;
      eow_q     <= 1'b0;
      data_q    <= '0;
      act_rtr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      act_rtr_q <= (state_d == IDLE) || (state_d == LOAD);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_q == DRAIN) && out_fire_c;
      if (act_fire_c) begin
        idx_q <= load_end_c ? '0 : idx_q + IDX_W'(1);
        len_q <= LEN_W'(idx_q) + LEN_W'(1);
        if (idx_last_c && !bus.act_eow_i) err_q <= 1'b1;
      end
      if (w_fire_c) begin
        data_q <= {bus.w_data_i, rd_c};
        sow_q  <= (idx_q == '0);
        eow_q  <= idx_last_c;
        rts_q  <= 1'b1;
        idx_q  <= idx_last_c ? '0 : idx_q + IDX_W'(1);
        if (idx_last_c) nrn_q <= nrn_last_c ? '0 : nrn_q + NRN_W'(1);
      end else if (out_fire_c) begin
        rts_q <= 1'b0;
      end
    end
  end

`ifdef POSITRON_FEEDER_NAR_CHECK_EN
  localparam logic [POSIT_WIDTH-1:0] NAR = {1'b1, {(POSIT_WIDTH-1){1'b0}}};
  logic nar_q;

  // A NaR on the very beat that starts a new vector still flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nar_q <= 1'b0;
    else if ((act_fire_c && bus.act_data_i == NAR) || (w_fire_c && bus.w_data_i == NAR))
      nar_q <= 1'b1;
    else if (act_fire_c && state_q == IDLE)
      nar_q <= 1'b0;
  end

  assign nar_o = nar_q;
`endif

  assign bus.act_rtr_o = act_rtr_q;
  assign bus.w_rtr_o   = w_rtr_c;
  assign bus.rts_o     = rts_q;
  assign bus.sow_o     = sow_q;
  assign bus.eow_o     = eow_q;
  assign bus.data_o    = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_positron_stream_feeder.sv
// Randomized bench for positron_stream_feeder: expected words come from a vector/weight reference queue.
module tb_positron_stream_feeder;
  localparam int unsigned PW = 16;
  localparam int unsigned VL = 4;
  localparam int unsigned NB = 2;
  localparam int unsigned NW = VL * NB;
  localparam logic [PW-1:0] NAR = 16'h8000;

  typedef struct packed {
    logic          sow;
    logic          eow;
    logic [2*PW-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err;
`ifdef POSITRON_FEEDER_NAR_CHECK_EN
  logic nar;
`endif

  always #5 clk = ~clk;

  positron_stream_feeder_if #(.POSIT_WIDTH(PW)) bus ();

  positron_stream_feeder #(.POSIT_WIDTH(PW), .VEC_LEN(VL), .NB_NEURONS(NB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
`ifdef POSITRON_FEEDER_NAR_CHECK_EN
    .nar_o(nar),
`endif
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [PW-1:0] act_v [VL];
  logic [PW-1:0] w_v [NW];
  word_t         exp_q [$];
  word_t         mon_w;
  bit            err_exp = 1'b0;
  bit            mon_en = 1'b0;
  bit            done_due = 1'b0;
  bit            hold_prev = 1'b0;
  logic [2*PW+1:0] prev;
  int            bp_mode = 0;
  int            fires = 0;
  int            cyc = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;

  function automatic logic [PW-1:0] rnd();
    logic [PW-1:0] v;
    v = PW'($urandom);
    if (v == NAR) v = v ^ PW'(1);
    return v;
  endfunction

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    bus.rtr_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.rtr_i = 1'b1;
        1:       bus.rtr_i = ~bus.rtr_i;
        default: bus.rtr_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops the reference queue on every downstream transfer.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("done", 64'(done), 64'(done_due));
      done_due = 1'b0;
      if (hold_prev) check("hold", 64'({bus.sow_o, bus.eow_o, bus.data_o}), 64'(prev));
      hold_prev = bus.rts_o & ~bus.rtr_i;
      prev = {bus.sow_o, bus.eow_o, bus.data_o};
      if (bus.rts_o && bus.rtr_i) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(bus.data_o), 64'hDEAD);
        end else begin
          mon_w = exp_q.pop_front();
          check("word", 64'({bus.sow_o, bus.eow_o, bus.data_o}), 64'(mon_w));
          if (fires == 0) first_cyc = cyc;
          last_cyc = cyc;
          fires++;
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
    end
  end

  task automatic send_act(input logic [PW-1:0] d, input bit e, input bit gap);
    bit took = 1'b0;
    int guard = 0;
    if (gap && $urandom_range(0, 2) == 0) begin
      @(posedge clk);
      #1;
    end
    bus.act_rts_i  = 1'b1;
    bus.act_data_i = d;
    bus.act_eow_i  = e;
    do begin
      @(negedge clk);
      took = bus.act_rtr_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!took && guard < 200);
    if (!took) check("act_timeout", 64'(0), 64'(1));
    bus.act_rts_i = 1'b0;
    bus.act_eow_i = 1'b0;
  endtask

  task automatic send_w(input logic [PW-1:0] d, input bit gap);
    bit took = 1'b0;
    int guard = 0;
    if (gap && $urandom_range(0, 2) == 0) begin
      bus.w_rts_i = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.w_rts_i  = 1'b1;
    bus.w_data_i = d;
    do begin
      @(negedge clk);
      took = bus.w_rtr_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!took && guard < 200);
    if (!took) check("w_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_case(input int nact, input bit give_eow, input int bp, input bit gap);
    logic [PW-1:0] a [VL];
    word_t wd;
    bit has_nar = 1'b0;
    for (int i = 0; i < int'(VL); i++) a[i] = (i < nact) ? act_v[i] : '0;
    for (int n = 0; n < int'(NB); n++)
      for (int i = 0; i < int'(VL); i++) begin
        wd.sow  = (i == 0);
        wd.eow  = (i == int'(VL) - 1);
        wd.data = {w_v[n*VL+i], a[i]};
        exp_q.push_back(wd);
        if (w_v[n*VL+i] == NAR) has_nar = 1'b1;
      end
    if (nact == int'(VL) && !give_eow) err_exp = 1'b1;
    fires   = 0;
    bp_mode = bp;
    mon_en  = 1'b1;
    for (int i = 0; i < nact; i++) send_act(act_v[i], give_eow && (i == nact - 1), gap);
    @(negedge clk);
    check("err", 64'(err), 64'(err_exp));
    check("busy_run", 64'(busy), 64'(1));
`ifdef POSITRON_FEEDER_NAR_CHECK_EN
    check("nar_cleared", 64'(nar), 64'(0));
`endif
    @(posedge clk);
    #1;
    fork
      begin
        for (int j = 0; j < int'(NW); j++) send_w(w_v[j], gap);
        bus.w_rts_i = 1'b0;
      end
      wait_done();
    join
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    check("busy_idle", 64'(busy), 64'(0));
    if (bp == 0 && !gap) check("gapless", 64'(last_cyc - first_cyc), 64'(NW - 1));
`ifdef POSITRON_FEEDER_NAR_CHECK_EN
    check("nar_flag", 64'(nar), 64'(has_nar));
`endif
  endtask

  task automatic reset_mid_stream();
    int cnt = 0;
    for (int i = 0; i < int'(VL); i++) act_v[i] = rnd();
    for (int i = 0; i < int'(VL); i++) send_act(act_v[i], i == int'(VL) - 1, 1'b0);
    bp_mode      = 0;
    bus.w_rts_i  = 1'b1;
    bus.w_data_i = rnd();
    for (int c = 0; c < 100 && cnt < 3; c++) begin
      @(negedge clk);
      if (bus.rts_o && bus.rtr_i) cnt++;
    end
    check("pre_reset_words", 64'(cnt), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({bus.rts_o, bus.sow_o, bus.eow_o, bus.data_o, busy, done, err,
                             bus.act_rtr_o, bus.w_rtr_o}), 64'(0));
    err_exp     = 1'b0;
    bus.w_rts_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.act_rts_i  = 1'b0;
    bus.act_eow_i  = 1'b0;
    bus.act_data_i = '0;
    bus.w_rts_i    = 1'b0;
    bus.w_data_i   = '0;
    #12;
    check("reset_state", 64'({bus.rts_o, bus.sow_o, bus.eow_o, bus.data_o, busy, done, err,
                              bus.act_rtr_o, bus.w_rtr_o}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: activations 1..4, weights 10..17, always ready.
    for (int i = 0; i < int'(VL); i++) act_v[i] = PW'(i + 1);
    for (int j = 0; j < int'(NW); j++) w_v[j] = PW'(j + 10);
    run_case(VL, 1'b1, 0, 1'b0);

    // Toggling backpressure with random data.
    for (int i = 0; i < int'(VL); i++) act_v[i] = rnd();
    for (int j = 0; j < int'(NW); j++) w_v[j] = rnd();
    run_case(VL, 1'b1, 1, 1'b0);

    // Early end of vector after two activations.
    act_v[0] = PW'(5);
    act_v[1] = PW'(6);
    for (int j = 0; j < int'(NW); j++) w_v[j] = rnd();
    run_case(2, 1'b1, 2, 1'b1);

    // Full vector without eow flags the error but still streams.
    for (int i = 0; i < int'(VL); i++) act_v[i] = rnd();
    for (int j = 0; j < int'(NW); j++) w_v[j] = rnd();
    run_case(VL, 1'b0, 0, 1'b0);

    reset_mid_stream();
    for (int i = 0; i < int'(VL); i++) act_v[i] = rnd();
    for (int j = 0; j < int'(NW); j++) w_v[j] = rnd();
    run_case(VL, 1'b1, 0, 1'b0);

    // Random lengths, ready patterns and gaps; one run carries a NaR weight.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(VL); i++) act_v[i] = rnd();
      for (int j = 0; j < int'(NW); j++) w_v[j] = rnd();
      if (r == 2) w_v[$urandom_range(0, NW - 1)] = NAR;
      run_case(int'($urandom_range(1, VL)), 1'b1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
